// File: rtl/sifh_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sifh_seq_ctrl
//   Sequencer for one SIFH measurement pass:
//     CLEAR (wipe SRAM) -> HIS1 (build histogram 1) -> PEAK1 -> FILT
//     -> HIS2 (build histogram 2) -> PEAK2 -> DONE -> IDLE
//   Every output is a register. Strobes pulse for the first cycle of the
//   state they launch.
//
// Parameters
//   RAM_ADDR    SRAM address width
//   CLEAR_DEPTH words cleared per pass (1 .. 2**RAM_ADDR)
//   TIMEOUT     watchdog limit in cycles (>= 2), only used with the watchdog
//
// Optional feature
//   SIFH_WATCHDOG_EN  when defined, each wait state (HIS1, PEAK1, FILT, HIS2,
//                     PEAK2) is bounded to TIMEOUT cycles. On expiry the pass
//                     is dropped to IDLE and err is set (sticky until the next
//                     start). Without it, waits are unbounded and err is 0.
//
// Ports
//   clk         in   clock, rising edge
//   res         in   asynchronous active-low reset
//   start       in   begin a pass (honoured in IDLE only)
//   abort       in   cancel the pass (any non-IDLE state)
//   his_done    in   histogram builder finished
//   peak_done   in   peak finder finished
//   filt_done   in   filter calculator finished
//   his_start   out  one-cycle builder launch
//   his_sel     out  0 = histogram 1, 1 = histogram 2
//   peak_start  out  one-cycle peak-finder launch
//   filt_start  out  one-cycle filter launch
//   wrEn        out  TDC enable (histogram build states only)
//   clr_we      out  SRAM clear write strobe
//   clr_waddr   out  SRAM clear address
//   ram_owner   out  SRAM grant: 0 clear, 1 builder, 2 peak, 3 filter
//   busy        out  pass in progress (state not IDLE)
//   done        out  one-cycle pass complete
//   err         out  sticky watchdog error
// -----------------------------------------------------------------------------
module sifh_seq_ctrl #(
    parameter int RAM_ADDR    = 10,
    parameter int CLEAR_DEPTH = 1024,
    parameter int TIMEOUT     = 65535
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                abort,
    input  logic                his_done,
    input  logic                peak_done,
    input  logic                filt_done,
    output logic                his_start,
    output logic                his_sel,
    output logic                peak_start,
    output logic                filt_start,
    output logic                wrEn,
    output logic                clr_we,
    output logic [RAM_ADDR-1:0] clr_waddr,
    output logic [1:0]          ram_owner,
    output logic                busy,
    output logic                done,
    output logic                err
);

    if (CLEAR_DEPTH < 1 || CLEAR_DEPTH > (1 << RAM_ADDR) || TIMEOUT < 2) begin : g_bad_params
        $error("sifh_seq_ctrl: CLEAR_DEPTH must be 1..2**RAM_ADDR and TIMEOUT >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_HIS1,
        S_PEAK1,
        S_FILT,
        S_HIS2,
        S_PEAK2,
        S_DONE
    } state_t;

    localparam logic [RAM_ADDR-1:0] LAST_ADDR = RAM_ADDR'(CLEAR_DEPTH - 1);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          w_owner;
    logic                w_entry;

    logic                r_his_start;
    logic                r_his_sel;
    logic                r_peak_start;
    logic                r_filt_start;
    logic                r_wren;
    logic                r_clr_we;
    logic [RAM_ADDR-1:0] r_clr_waddr;
    logic [1:0]          r_owner;
    logic                r_busy;
    logic                r_done;

`ifdef SIFH_WATCHDOG_EN
    localparam int            WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0]     r_wdog;
    logic                r_err;
    logic                w_wait;
    logic                w_timeout;
`endif

    // Next state. Done inputs are only looked at in the state that waits for
    // them; abort overrides everything, including a watchdog expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)                    w_next = S_CLEAR;
            S_CLEAR: if (r_clr_waddr == LAST_ADDR) w_next = S_HIS1;
            S_HIS1:  if (his_done)                 w_next = S_PEAK1;
            S_PEAK1: if (peak_done)                w_next = S_FILT;
            S_FILT:  if (filt_done)                w_next = S_HIS2;
            S_HIS2:  if (his_done)                 w_next = S_PEAK2;
            S_PEAK2: if (peak_done)                w_next = S_DONE;
            S_DONE:                                w_next = S_IDLE;
            default:                               w_next = S_IDLE;
        endcase

`ifdef SIFH_WATCHDOG_EN
        w_wait    = (r_state inside {S_HIS1, S_PEAK1, S_FILT, S_HIS2, S_PEAK2});
        // Expiry only counts when the expected done did not arrive this cycle.
        w_timeout = w_wait && (r_wdog == WD_LAST) && (w_next == r_state) && !abort;
        if (w_timeout) begin
            w_next = S_IDLE;
        end
`endif

        if (abort && r_state != S_IDLE) begin
            w_next = S_IDLE;
        end

        w_entry = (w_next != r_state);

        case (w_next)
            S_HIS1, S_HIS2:   w_owner = 2'd1;
            S_PEAK1, S_PEAK2: w_owner = 2'd2;
            S_FILT:           w_owner = 2'd3;
            default:          w_owner = 2'd0;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // register; launch strobes are gated by the state change.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state      <= S_IDLE;
            r_his_start  <= 1'b0;
            r_his_sel    <= 1'b0;
            r_peak_start <= 1'b0;
            r_filt_start <= 1'b0;
            r_wren       <= 1'b0;
            r_clr_we     <= 1'b0;
            r_clr_waddr  <= '0;
            r_owner      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef SIFH_WATCHDOG_EN
            r_wdog       <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_state      <= w_next;
            r_his_start  <= w_entry && (w_next inside {S_HIS1, S_HIS2});
            r_peak_start <= w_entry && (w_next inside {S_PEAK1, S_PEAK2});
            r_filt_start <= w_entry && (w_next == S_FILT);
            r_his_sel    <= (w_next inside {S_HIS2, S_PEAK2});
            r_wren       <= (w_next inside {S_HIS1, S_HIS2});
            r_clr_we     <= (w_next == S_CLEAR);
            r_owner      <= w_owner;
            r_busy       <= (w_next != S_IDLE);
            r_done       <= (w_next == S_DONE);

            // Address starts at 0 on CLEAR entry and steps once per write.
            if (r_state == S_CLEAR && w_next == S_CLEAR) begin
                r_clr_waddr <= r_clr_waddr + RAM_ADDR'(1);
            end else begin
                r_clr_waddr <= '0;
            end

`ifdef SIFH_WATCHDOG_EN
            if (w_entry) begin
                r_wdog <= '0;
            end else if (w_wait) begin
                r_wdog <= r_wdog + WD_W'(1);
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (r_state == S_IDLE && start) begin
                r_err <= 1'b0;
            end
`endif
        end
    end

    assign his_start  = r_his_start;
    assign his_sel    = r_his_sel;
    assign peak_start = r_peak_start;
    assign filt_start = r_filt_start;
    assign wrEn       = r_wren;
    assign clr_we     = r_clr_we;
    assign clr_waddr  = r_clr_waddr;
    assign ram_owner  = r_owner;
    assign busy       = r_busy;
    assign done       = r_done;
`ifdef SIFH_WATCHDOG_EN
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sifh_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sifh_seq_ctrl
//   Self-checking bench for sifh_seq_ctrl (CLEAR_DEPTH=4, TIMEOUT=8).
//   Directed vector table, hand-written multi-cycle sequences, then random
//   stimulus compared against a pass-level reference model.
// -----------------------------------------------------------------------------
module tb_sifh_seq_ctrl;

    localparam int RAM_ADDR    = 4;
    localparam int CLEAR_DEPTH = 4;
    localparam int TIMEOUT     = 8;
`ifdef SIFH_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    // Builder/finder response delay; kept inside the watchdog window when enabled.
    localparam int RESP_DLY = WD_EN ? 5 : 10;

    logic                clk = 1'b0;
    logic                res;
    logic                start;
    logic                abort;
    logic                his_done;
    logic                peak_done;
    logic                filt_done;
    logic                his_start;
    logic                his_sel;
    logic                peak_start;
    logic                filt_start;
    logic                wrEn;
    logic                clr_we;
    logic [RAM_ADDR-1:0] clr_waddr;
    logic [1:0]          ram_owner;
    logic                busy;
    logic                done;
    logic                err;

    always #5 clk = ~clk;

    sifh_seq_ctrl #(
        .RAM_ADDR    (RAM_ADDR),
        .CLEAR_DEPTH (CLEAR_DEPTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .abort      (abort),
        .his_done   (his_done),
        .peak_done  (peak_done),
        .filt_done  (filt_done),
        .his_start  (his_start),
        .his_sel    (his_sel),
        .peak_start (peak_start),
        .filt_start (filt_start),
        .wrEn       (wrEn),
        .clr_we     (clr_we),
        .clr_waddr  (clr_waddr),
        .ram_owner  (ram_owner),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // {his_start, his_sel, peak_start, filt_start, wrEn, clr_we, ram_owner, busy, done, err}
    function automatic logic [10:0] outs();
        return {his_start, his_sel, peak_start, filt_start, wrEn, clr_we,
                ram_owner, busy, done, err};
    endfunction

    // ---------------- reference model ----------------
    // A pass is a clear phase (stage -1), five wait stages (0..4) each waiting
    // for one done source, then a one-cycle done stage (5).
    // Source index: 0 = histogram builder, 1 = peak finder, 2 = filter.
    int stage_src [5] = '{0, 1, 2, 0, 1};

    bit m_active;
    int m_stage;
    int m_addr;
    int m_wd;
    bit m_err;
    bit m_entered;

    task automatic model_reset();
        m_active  = 1'b0;
        m_stage   = 0;
        m_addr    = 0;
        m_wd      = 0;
        m_err     = 1'b0;
        m_entered = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic h,
                              input logic p, input logic f);
        logic d [3];
        d[0] = h;
        d[1] = p;
        d[2] = f;
        m_entered = 1'b0;
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_stage  = -1;
                m_addr   = 0;
                m_err    = 1'b0;
            end
        end else if (a) begin
            m_active = 1'b0;
        end else if (m_stage == -1) begin
            if (m_addr == CLEAR_DEPTH - 1) begin
                m_stage   = 0;
                m_wd      = 0;
                m_entered = 1'b1;
            end else begin
                m_addr++;
            end
        end else if (m_stage == 5) begin
            m_active = 1'b0;
        end else if (d[stage_src[m_stage]]) begin
            m_stage++;
            m_wd      = 0;
            m_entered = 1'b1;
        end else if (WD_EN && m_wd == TIMEOUT - 1) begin
            m_active = 1'b0;
            m_err    = 1'b1;
        end else begin
            m_wd++;
        end
    endtask

    function automatic logic [10:0] model_outs();
        bit         waiting;
        int         src;
        logic [1:0] own;
        waiting = m_active && m_stage >= 0 && m_stage <= 4;
        src     = waiting ? stage_src[m_stage] : -1;
        own     = waiting ? 2'(src + 1) : 2'd0;
        return {waiting && m_entered && src == 0,
                waiting && m_stage >= 3,
                waiting && m_entered && src == 1,
                waiting && m_entered && src == 2,
                waiting && src == 0,
                m_active && m_stage == -1,
                own,
                m_active,
                m_active && m_stage == 5,
                m_err};
    endfunction

    // ---------------- drivers ----------------
    task automatic cyc(input logic s, input logic a, input logic h,
                       input logic p, input logic f);
        start     = s;
        abort     = a;
        his_done  = h;
        peak_done = p;
        filt_done = f;
        @(posedge clk);
        #1;
        model_step(s, a, h, p, f);
    endtask

    // Answer each wait state immediately until the given grant/select is reached.
    task automatic advance_to(input logic [1:0] own, input logic sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy && !clr_we && ram_owner == own && his_sel == sel) begin
                ok = 1'b1;
                break;
            end
            cyc(1'b0, 1'b0, ram_owner == 2'd1, ram_owner == 2'd2, ram_owner == 2'd3);
        end
    endtask

    typedef struct {
        logic        s, a, h, p, f;
        logic [10:0] exp;
        int          addr;   // -1: address not checked
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t tbl [15];
        int   owner_log [$];
        int   exp_own [7];
        int   cd_h, cd_p, cd_f, iters, n_done, late_done;
        bit   sel2, ok;
        logic h, p, f;

        exp_own = '{0, 1, 2, 3, 1, 2, 0};

        tbl[0]  = '{1, 0, 0, 0, 0, 11'b00000100100,  0};  // start -> CLEAR
        tbl[1]  = '{0, 0, 0, 0, 0, 11'b00000100100,  1};
        tbl[2]  = '{0, 0, 0, 0, 0, 11'b00000100100,  2};
        tbl[3]  = '{0, 0, 0, 0, 0, 11'b00000100100,  3};
        tbl[4]  = '{0, 0, 0, 0, 0, 11'b10001001100, -1};  // HIS1 entry
        tbl[5]  = '{0, 0, 0, 1, 1, 11'b00001001100, -1};  // wrong dones ignored
        tbl[6]  = '{0, 0, 1, 0, 0, 11'b00100010100, -1};  // PEAK1 entry
        tbl[7]  = '{0, 0, 1, 0, 0, 11'b00000010100, -1};  // his_done ignored
        tbl[8]  = '{0, 0, 0, 1, 0, 11'b00010011100, -1};  // FILT entry
        tbl[9]  = '{0, 0, 0, 0, 1, 11'b11001001100, -1};  // HIS2 entry
        tbl[10] = '{0, 0, 1, 0, 0, 11'b01100010100, -1};  // PEAK2 entry
        tbl[11] = '{0, 0, 0, 1, 0, 11'b00000000110, -1};  // DONE
        tbl[12] = '{1, 0, 0, 0, 0, 11'b00000000000, -1};  // start ignored in DONE
        tbl[13] = '{1, 0, 1, 0, 0, 11'b00000100100,  0};  // start + stray done
        tbl[14] = '{0, 1, 0, 0, 0, 11'b00000000000, -1};  // abort in CLEAR

        // ---- reset state ----
        res = 1'b0; start = 1'b0; abort = 1'b0;
        his_done = 1'b0; peak_done = 1'b0; filt_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_addr", 32'(clr_waddr), 32'd0);
        res = 1'b1;

        // ---- directed vector table ----
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].s, tbl[i].a, tbl[i].h, tbl[i].p, tbl[i].f);
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
            if (tbl[i].addr >= 0)
                check($sformatf("vec%0d_addr", i), 32'(clr_waddr), 32'(tbl[i].addr));
        end

        // ---- full pass with delayed responses ----
        cd_h = -1; cd_p = -1; cd_f = -1;
        iters = 0; n_done = 0; sel2 = 1'b0;
        owner_log.push_back(int'(ram_owner));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        while (busy && iters < 400) begin
            h = (cd_h == 0);
            p = (cd_p == 0);
            f = (cd_f == 0);
            if (cd_h >= 0) cd_h--;
            if (cd_p >= 0) cd_p--;
            if (cd_f >= 0) cd_f--;
            cyc(1'b0, 1'b0, h, p, f);
            iters++;
            if (his_start)  cd_h = RESP_DLY;
            if (peak_start) cd_p = RESP_DLY;
            if (filt_start) cd_f = RESP_DLY;
            if (int'(ram_owner) != owner_log[$]) owner_log.push_back(int'(ram_owner));
            if (done) n_done++;
            if (his_sel && wrEn) sel2 = 1'b1;
        end
        check("pass_bounded", 32'(iters < 400), 32'd1);
        check("owner_seq_len", 32'(owner_log.size()), 32'd7);
        if (owner_log.size() == 7) begin
            for (int k = 0; k < 7; k++)
                check($sformatf("owner_seq%0d", k), 32'(owner_log[k]), 32'(exp_own[k]));
        end
        check("pass_done_pulses", 32'(n_done), 32'd1);
        check("pass_his_sel2", 32'(sel2), 32'd1);
        check("pass_busy_after", 32'(busy), 32'd0);

        // ---- abort coinciding with his_done in HIS2 ----
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        advance_to(2'd1, 1'b1, ok);
        check("reach_his2", 32'(ok), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_outs", 32'(outs()), 32'd0);
        late_done = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (done || busy) late_done++;
        end
        check("abort_stays_idle", 32'(late_done), 32'd0);

        // ---- asynchronous reset in PEAK1, then restart ----
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        advance_to(2'd2, 1'b0, ok);
        check("reach_peak1", 32'(ok), 32'd1);
        #2;
        res = 1'b0;
        #1;
        check("async_reset_outs", 32'(outs()), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        res = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_addr0", 32'(clr_waddr), 32'd0);
        check("restart_clr_we", 32'(clr_we), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_addr1", 32'(clr_waddr), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef SIFH_WATCHDOG_EN
        // ---- watchdog expiry in FILT ----
        begin
            int n_filt;
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            advance_to(2'd3, 1'b0, ok);
            check("reach_filt", 32'(ok), 32'd1);
            n_filt = 1;
            for (int i = 0; i < 50; i++) begin
                cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                if (ram_owner != 2'd3) break;
                n_filt++;
            end
            check("wd_filt_cycles", 32'(n_filt), 32'(TIMEOUT));
            check("wd_err_set", 32'(err), 32'd1);
            check("wd_idle", 32'(busy), 32'd0);
            check("wd_no_done", 32'(done), 32'd0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("wd_err_cleared", 32'(err), 32'd0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
`endif

        // ---- random stimulus against the model ----
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0);
            check($sformatf("rand%0d_outs", i), 32'(outs()), 32'(model_outs()));
            if (m_active && m_stage == -1)
                check($sformatf("rand%0d_addr", i), 32'(clr_waddr), 32'(m_addr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sifh_seq_ctrl.md
SIFH_SEQ_CTRL -- requirements
Module: sifh_seq_ctrl

Interface
REQ-001 SHALL have parameter RAM_ADDR, default 10: SRAM address width.
REQ-002 SHALL have parameter CLEAR_DEPTH, default 1024: words cleared per pass; 1..2^RAM_ADDR.
REQ-003 SHALL have parameter TIMEOUT, default 65535: watchdog limit in cycles, >=2.
REQ-004 SHALL have ports:
- clk  in  1  clock, rising edge.
- res  in  1  reset, asynchronous, active-low.
- start  in  1  begin measurement pass.
- abort  in  1  cancel pass.
- his_done  in  1  histogram builder finished.
- peak_done  in  1  peak finder finished.
- filt_done  in  1  filter calculator finished.
- his_start  out  1  one-cycle builder launch.
- his_sel  out  1  0 = histogram 1, 1 = histogram 2.
- peak_start  out  1  one-cycle peak-finder launch.
- filt_start  out  1  one-cycle filter launch.
- wrEn  out  1  TDC enable.
- clr_we  out  1  SRAM clear write strobe (mea and wEnable).
- clr_waddr  out  RAM_ADDR  clear address.
- ram_owner  out  2  SRAM port grant: 0 clear, 1 builder, 2 peak, 3 filter.
- busy  out  1  state not IDLE.
- done  out  1  one-cycle pass complete.
- err  out  1  sticky watchdog error.

Function
REQ-005 SHALL implement states IDLE, CLEAR, HIS1, PEAK1, FILT, HIS2, PEAK2, DONE, all registered outputs.
REQ-006 IDLE: start=1 SHALL enter CLEAR next cycle and clear err; start is ignored in all other states.
REQ-007 CLEAR: clr_we=1, clr_waddr 0 on entry, +1 per cycle; after the write at CLEAR_DEPTH-1, SHALL enter HIS1 next cycle with clr_we=0 (CLEAR_DEPTH write cycles exactly).
REQ-008 Entry to HIS1/HIS2 SHALL pulse his_start for the first state cycle; his_sel=0 in HIS1, 1 in HIS2/PEAK2; wrEn=1 only in HIS1/HIS2.
REQ-009 his_done in HIS1 -> PEAK1; peak_done in PEAK1 -> FILT; filt_done in FILT -> HIS2; his_done in HIS2 -> PEAK2; peak_done in PEAK2 -> DONE; each transition one cycle after the done is sampled.
REQ-010 Entry to PEAK1/PEAK2 SHALL pulse peak_start, entry to FILT SHALL pulse filt_start, one cycle each.
REQ-011 Done inputs not matching the current state SHALL be ignored, including one coinciding with a start pulse.
REQ-012 ram_owner SHALL be 0 in IDLE/CLEAR/DONE, 1 in HIS1/HIS2, 2 in PEAK1/PEAK2, 3 in FILT.
REQ-013 DONE SHALL assert done for one cycle and return to IDLE.
REQ-014 abort=1 in any non-IDLE state SHALL enter IDLE next cycle, deasserting all strobes and wrEn, no done; abort has priority over every done input.
REQ-015 busy SHALL be 1 in every state except IDLE.

Reset
REQ-016 res=0 SHALL immediately force IDLE and all outputs 0, including err and clr_waddr.
REQ-017 Reset mid-pass SHALL discard progress; the next start restarts from CLEAR.

Configuration
REQ-018 With SIFH_WATCHDOG_EN defined, a counter SHALL clear on every state entry and count in HIS1, PEAK1, FILT, HIS2, PEAK2; reaching TIMEOUT-1 without the expected done SHALL enter IDLE next cycle with err=1, no done.
REQ-019 Without SIFH_WATCHDOG_EN, no counter SHALL exist, err SHALL be constant 0, waits are unbounded.

Verification
REQ-020 CLEAR_DEPTH=4, start pulse -> clr_we high 4 cycles, clr_waddr 0,1,2,3, then his_start pulse, wrEn=1, his_sel=0.
REQ-021 Full pass, each done 10 cycles after its start strobe -> owner sequence 0,1,2,3,1,2,0, his_sel=1 in second build, one done pulse, busy 0 after.
REQ-022 peak_done and filt_done asserted during HIS1 -> no transition; his_done then -> PEAK1.
REQ-023 abort together with his_done in HIS2 -> IDLE, done never asserts, wrEn 0 next cycle.
REQ-024 Watchdog enabled, TIMEOUT=8, no filt_done -> IDLE after 8 FILT cycles, err=1; next start clears err.
REQ-025 res low during PEAK1 -> outputs 0 immediately; start after release -> clr_waddr restarts at 0.
